// File: rtl/onchip_ram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_reader_pkg
// Brief    : Shared types and default widths for the on-chip RAM block reader.
// Revision : 1.0 - initial release
// ============================================================================
package onchip_ram_reader_pkg;

  // Default geometry of the 1024 x 32 work RAM and the reader's output buffer
  localparam int C_ADDR_W_DEF     = 10;
  localparam int C_DATA_W_DEF     = 32;
  localparam int C_LEN_W_DEF      = 11;
  localparam int C_FIFO_DEPTH_DEF = 4;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

endpackage : onchip_ram_reader_pkg
`default_nettype wire

// File: rtl/onchip_ram_block_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reader_sync_fifo
// Brief    : DEPTH x DATA_W synchronous FIFO with occupancy count. Push and
//            pop may occur together, including when full (the pop frees the
//            slot) and when empty (no bypass: the pushed word appears on the
//            read port in the following cycle). Read data is forced to zero
//            while empty so the stream output is clean out of reset.
// Revision : 1.0 - initial release
// ============================================================================
module reader_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL);
  assign w_do_pop  = i_pop && !w_empty;
  // A push at full is only legal when a pop frees a slot in the same cycle
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage array; contents need no reset because reads are masked when empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : reader_sync_fifo
`default_nettype wire

// File: rtl/onchip_ram_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_block_reader
// Brief    : Drains a window of words from the single-port on-chip work RAM
//            and presents it as a valid/ready word stream. A credit check
//            (buffered + in-flight reads) against the output FIFO absorbs the
//            RAM's one-cycle read latency and downstream backpressure while
//            sustaining one word per cycle.
// Config   : ONCHIP_RAM_READER_BYTESWAP_EN - byte-reverse each RAM word as it
//            is written into the FIFO (big-endian message words).
// Revision : 1.0 - initial release
// ============================================================================
module onchip_ram_block_reader
  import onchip_ram_reader_pkg::*;
#(
  parameter int ADDR_W     = C_ADDR_W_DEF,
  parameter int DATA_W     = C_DATA_W_DEF,
  parameter int LEN_W      = C_LEN_W_DEF,
  parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic              o_ram_chipselect,
  output logic              o_ram_write,
  input  logic [DATA_W-1:0] i_ram_readdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_READ  = 2'(ST_READ);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0]  C_DEPTH    = SUM_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0]  C_LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem_issue;
  logic [LEN_W-1:0]  r_rem_deliver;
  logic              r_inflight;

  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic [DATA_W-1:0] w_wr_data;
  logic [SUM_W-1:0]  w_credit_sum;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_pop;
  logic              w_accept;

  // Buffered words plus the read still in flight must leave room for one more
  assign w_credit_sum = SUM_W'(w_fifo_count) + SUM_W'(r_inflight);
  assign w_credit_ok  = (w_credit_sum < C_DEPTH);
  assign w_issue      = (r_state == S_READ) && w_credit_ok;
  assign w_pop        = !w_fifo_empty && i_out_ready;
  assign w_accept     = (r_state == S_IDLE) && i_start;

  // Next-state selection for the transfer sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_issue && (r_rem_issue == C_LEN_ONE)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the final word is accepted so done follows it directly
        if ((r_rem_deliver == '0) || (w_pop && (r_rem_deliver == C_LEN_ONE))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state, address/length counters and read-latency tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_rem_issue   <= '0;
      r_rem_deliver <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr        <= i_base_addr;
        r_rem_issue   <= i_length;
        r_rem_deliver <= i_length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + C_ADDR_ONE;
          r_rem_issue <= r_rem_issue - C_LEN_ONE;
        end
        if (w_pop) begin
          r_rem_deliver <= r_rem_deliver - C_LEN_ONE;
        end
      end
    end
  end

`ifdef ONCHIP_RAM_READER_BYTESWAP_EN
  localparam int NBYTES = DATA_W / 8;
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bswap
    assign w_wr_data[8*gi +: 8] = i_ram_readdata[8*(NBYTES-1-gi) +: 8];
  end
`else
  assign w_wr_data = i_ram_readdata;
`endif

  // Returning read data is pushed unconditionally; the credit check keeps
  // the FIFO from overflowing. A reset clears r_inflight, dropping any
  // word still returning from the RAM.
  reader_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_wdata (w_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_ram_address    = r_addr;
  assign o_ram_chipselect = w_issue;
  assign o_ram_write      = 1'b0;
  assign o_out_data       = w_fifo_rdata;
  assign o_out_valid      = !w_fifo_empty;
  assign o_out_last       = !w_fifo_empty && (r_rem_deliver == C_LEN_ONE);

endmodule : onchip_ram_block_reader
`default_nettype wire

// File: tb/tb_onchip_ram_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_ram_block_reader
// Brief    : Directed bench for onchip_ram_block_reader with a RAM model and
//            an address/word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_ram_block_reader;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 11;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write;
  logic [DATA_W-1:0] ram_readdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;

  always #5 clk = ~clk;

  onchip_ram_block_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_start          (start),
    .i_base_addr      (base_addr),
    .i_length         (length),
    .o_busy           (busy),
    .o_done           (done),
    .o_ram_address    (ram_address),
    .o_ram_chipselect (ram_chipselect),
    .o_ram_write      (ram_write),
    .i_ram_readdata   (ram_readdata),
    .o_out_data       (out_data),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_last       (out_last)
  );

  // RAM model: one-cycle read latency
  logic [DATA_W-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_chipselect) ram_readdata <= mem[ram_address];
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        q_word[$];
  logic [9:0]  q_addr[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int iss_cnt = 0, pop_cnt = 0, cs_seen = 0, valid_seen = 0, done_cnt = 0;
  int first_valid_cyc = -1, last_cyc = -1, done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w;
    w = mem[a];
`ifdef ONCHIP_RAM_READER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Monitor: compares issued addresses and stream words against the queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_chipselect) begin
        cs_seen++;
        iss_cnt++;
        check("credit_limit", 32'((iss_cnt - pop_cnt) <= FIFO_DEPTH), 32'd1);
        if (q_addr.size() == 0) check("unexpected_issue", 32'(ram_chipselect), 32'd0);
        else check("issue_addr", 32'(ram_address), 32'(q_addr.pop_front()));
      end
      if (out_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (q_word.size() == 0) begin
          check("unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", out_data, q_word[0].data);
          check("out_last", 32'(out_last), 32'(q_word[0].last));
          if (out_ready) begin
            if (out_last) last_cyc = cyc;
            void'(q_word.pop_front());
            pop_cnt++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input int base, input int len);
    exp_t e;
    int   a;
    iss_cnt = 0; pop_cnt = 0;
    first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % 1024;
      q_addr.push_back(10'(a));
      e.data = exp_word(a);
      e.last = (i == len - 1);
      q_word.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(base); length = LEN_W'(len);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 99) >= 30);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < 400), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_addr_q_empty"}, 32'(q_addr.size()), 32'd0);
    check({tag, "_word_q_empty"}, 32'(q_word.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_cs"},    32'(ram_chipselect), 32'd0);
    check({tag, "_addr"},  32'(ram_address), 32'd0);
    check({tag, "_write"}, 32'(ram_write), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_data"},  out_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, cs0, v0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem[100] = 32'h11223344;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;

    // 16 words from base 0, no backpressure: cycle-accurate timing
    d0 = done_cnt;
    start_xfer(0, 16);
    check("t1_busy_c1", 32'(busy), 32'd1);
    check("t1_cs_c1", 32'(ram_chipselect), 32'd1);
    wait_idle("t1", 1'b0);
    check("t1_first_valid_cyc", 32'(first_valid_cyc - t0), 32'd3);
    check("t1_last_cyc", 32'(last_cyc - t0), 32'd18);
    check("t1_done_cyc", 32'(done_cyc - t0), 32'd19);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // Address wrap 1020..1023, 0..3
    start_xfer(1020, 8);
    wait_idle("t2", 1'b0);

    // Random backpressure, 30% not-ready
    start_xfer(50, 16);
    wait_idle("t3", 1'b1);

    // Zero-length transfer
    cs0 = cs_seen; v0 = valid_seen; d0 = done_cnt;
    start_xfer(5, 0);
    check("t4_busy_c1", 32'(busy), 32'd1);
    check("t4_done_c1", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("t4_busy_c2", 32'(busy), 32'd0);
    check("t4_no_cs", 32'(cs_seen - cs0), 32'd0);
    check("t4_no_valid", 32'(valid_seen - v0), 32'd0);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored
    d0 = done_cnt;
    start_xfer(200, 4);
    start = 1'b1; base_addr = 10'd300; length = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t5", 1'b0);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset in cycle 6 of a 16-word transfer
    start_xfer(0, 16);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q_addr.delete();
    q_word.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    v0 = valid_seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_stale_word", 32'(valid_seen - v0), 32'd0);
    start_xfer(0, 16);
    wait_idle("t6", 1'b0);
    check("t6_first_valid_cyc", 32'(first_valid_cyc - t0), 32'd3);
    check("t6_done_cyc", 32'(done_cyc - t0), 32'd19);

    // Single word with distinct bytes (swap visible when enabled)
    start_xfer(100, 1);
    wait_idle("t7", 1'b0);
    check("t7_last_cyc", 32'(last_cyc - t0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_onchip_ram_block_reader
`default_nettype wire
